// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
// Parametrised serial-pattern detector. One bit is consumed per qualified
// cycle; each occurrence of PATTERN (MSB received first) is flagged both
// combinationally (mealy, same cycle as the completing bit) and registered
// (moore, the cycle after).
//
// Optional feature macro: SEQDET_HIT_COUNT_EN
//   defined   -> saturating match counter drives hit_count
//   undefined -> no counter; hit_count is tied to zero
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous, active-low reset
//   en         in   detector enable (low parks the FSM in S_IDLE)
//   clear      in   synchronous clear of window, fill count and hit_count
//   x_valid    in   qualifies x_in for this cycle
//   x_in       in   serial data bit
//   mealy      out  current bit completes PATTERN (combinational)
//   moore      out  registered pulse in the cycle after a match
//   hit_count  out  [CNT_W-1:0] saturating match counter
//   armed      out  window holds at least PAT_LEN-1 valid bits
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
   parameter int                 PAT_LEN = 3,
   parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clear,
   input  logic             x_valid,
   input  logic             x_in,
   output logic             mealy,
   output logic             moore,
   output logic [CNT_W-1:0] hit_count,
   output logic             armed
);

   localparam int                FILL_W   = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_ARMED = 2'd2,
      S_HIT   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [PAT_LEN-2:0] hist, hist_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic [PAT_LEN-1:0] window;
   logic               accept;
   logic               match;

   assign accept = en & x_valid & ~clear;
   assign window = {hist, x_in};
   // fill==FILL_MAX guarantees every window bit came from the live stream
   assign match  = accept & ((state == S_ARMED) | (state == S_HIT)) &
                   (fill == FILL_MAX) & (window == PATTERN);

   assign mealy = match;
   assign moore = (state == S_HIT);
   assign armed = (fill == FILL_MAX) & (state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         hist  <= '0;
         fill  <= '0;
      end else begin
         state <= state_nxt;
         hist  <= hist_nxt;
         fill  <= fill_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill;
      if (!en) begin
         state_nxt = S_IDLE;
         fill_nxt  = '0;
      end else if (clear) begin
         state_nxt = S_FILL;
         fill_nxt  = '0;
         hist_nxt  = '0;
      end else if (match) begin
         state_nxt = S_HIT;
         if (OVERLAP) begin
            // tail of this match may begin the next one
            hist_nxt = window[PAT_LEN-2:0];
         end else begin
            fill_nxt = '0;
            hist_nxt = '0;
         end
      end else if (accept) begin
         hist_nxt = window[PAT_LEN-2:0];
         if (fill != FILL_MAX) begin
            fill_nxt = fill + 1'b1;
         end
         state_nxt = (fill_nxt == FILL_MAX) ? S_ARMED : S_FILL;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_FILL;
            S_FILL:  state_nxt = S_FILL;
            S_ARMED: state_nxt = S_ARMED;
            S_HIT:   state_nxt = OVERLAP ? S_ARMED : S_FILL;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

`ifdef SEQDET_HIT_COUNT_EN
   logic [CNT_W-1:0] cnt;

   // en=0 has priority over clear, so the count holds while disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (en && clear) begin
         cnt <= '0;
      end else if (match && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign hit_count = cnt;
`else
   assign hit_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
module tb_seq_detect_fsm;

   logic clk = 1'b0;
   logic reset_n;
   logic en;
   logic clear;
   logic x_valid;
   logic x_in;

   logic       mealy_o, moore_o, armed_o;
   logic [1:0] hc_o;
   logic       mealy_n, moore_n, armed_n;
   logic [7:0] hc_n;

   int tests    = 0;
   int failures = 0;

`ifdef SEQDET_HIT_COUNT_EN
   localparam bit HC_EN = 1'b1;
`else
   localparam bit HC_EN = 1'b0;
`endif

   typedef struct {
      logic       moore;
      logic       armed;
      logic [7:0] cnt;
   } exp_t;

   exp_t q_o[$];
   exp_t q_n[$];

   // reference state: accepted-bit count, last two bits, hits
   int         len_o,  len_n;
   logic [1:0] hist_o, hist_n;
   int         cnt_o,  cnt_n;

   always #5 clk = ~clk;

   seq_detect_fsm #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_ov (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x_valid(x_valid), .x_in(x_in),
      .mealy(mealy_o), .moore(moore_o), .hit_count(hc_o), .armed(armed_o)
   );

   seq_detect_fsm #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .x_valid(x_valid), .x_in(x_in),
      .mealy(mealy_n), .moore(moore_n), .hit_count(hc_n), .armed(armed_n)
   );

   task automatic mdl(input bit ovl, input int sat, input logic e, input logic c,
                      input logic v, input logic x, inout int len,
                      inout logic [1:0] hist, inout int cnt, output logic m);
      m = 1'b0;
      if (!e) begin
         len = 0;
      end else if (c) begin
         len = 0; hist = 2'b00; cnt = 0;
      end else if (v) begin
         if (len == 2 && hist == 2'b10 && x == 1'b1) begin
            m = 1'b1;
            if (cnt < sat) cnt++;
            if (ovl) hist = {hist[0], x};
            else begin hist = 2'b00; len = 0; end
         end else begin
            hist = {hist[0], x};
            if (len < 2) len++;
         end
      end
   endtask

   task automatic step(input logic e, input logic c, input logic v, input logic x);
      logic m_o, m_n;
      exp_t eo, en_e, go, gn;
      @(negedge clk);
      en = e; clear = c; x_valid = v; x_in = x;
      #1;
      mdl(1'b1, 3,   e, c, v, x, len_o, hist_o, cnt_o, m_o);
      mdl(1'b0, 255, e, c, v, x, len_n, hist_n, cnt_n, m_n);
      tests++;
      if (mealy_o !== m_o) begin
         failures++;
         $display("FAIL mealy_ov t=%0t got=%b exp=%b", $time, mealy_o, m_o);
      end
      tests++;
      if (mealy_n !== m_n) begin
         failures++;
         $display("FAIL mealy_nov t=%0t got=%b exp=%b", $time, mealy_n, m_n);
      end
      eo.moore   = m_o;
      eo.armed   = e && (len_o == 2);
      eo.cnt     = HC_EN ? 8'(cnt_o) : 8'd0;
      en_e.moore = m_n;
      en_e.armed = e && (len_n == 2);
      en_e.cnt   = HC_EN ? 8'(cnt_n) : 8'd0;
      q_o.push_back(eo);
      q_n.push_back(en_e);
      @(posedge clk);
      #1;
      tests++;
      if (q_o.size() == 0 || q_n.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
         go = q_o.pop_front();
         gn = q_n.pop_front();
         if (moore_o !== go.moore) begin
            failures++;
            $display("FAIL moore_ov t=%0t got=%b exp=%b", $time, moore_o, go.moore);
         end
         tests++;
         if (armed_o !== go.armed) begin
            failures++;
            $display("FAIL armed_ov t=%0t got=%b exp=%b", $time, armed_o, go.armed);
         end
         tests++;
         if (8'(hc_o) !== go.cnt) begin
            failures++;
            $display("FAIL hit_count_ov t=%0t got=%0d exp=%0d", $time, hc_o, go.cnt);
         end
         tests++;
         if (moore_n !== gn.moore) begin
            failures++;
            $display("FAIL moore_nov t=%0t got=%b exp=%b", $time, moore_n, gn.moore);
         end
         tests++;
         if (armed_n !== gn.armed) begin
            failures++;
            $display("FAIL armed_nov t=%0t got=%b exp=%b", $time, armed_n, gn.armed);
         end
         tests++;
         if (hc_n !== gn.cnt) begin
            failures++;
            $display("FAIL hit_count_nov t=%0t got=%0d exp=%0d", $time, hc_n, gn.cnt);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      tests++;
      if ({mealy_o, moore_o, armed_o, hc_o} !== 5'b0) begin
         failures++;
         $display("FAIL %s_ov got=%b%b%b%0d exp=0000", tag, mealy_o, moore_o, armed_o, hc_o);
      end
      tests++;
      if ({mealy_n, moore_n, armed_n} !== 3'b0 || hc_n !== 8'd0) begin
         failures++;
         $display("FAIL %s_nov got=%b%b%b%0d exp=0000", tag, mealy_n, moore_n, armed_n, hc_n);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      en = 1'b1; clear = 1'b0; x_valid = 1'b1; x_in = 1'b1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs({tag, "_async"});
      len_o = 0; hist_o = 2'b00; cnt_o = 0;
      len_n = 0; hist_n = 2'b00; cnt_n = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs({tag, "_held"});
      @(negedge clk);
      en = 1'b0; x_valid = 1'b0; x_in = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic send(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b1, 1'b0, 1'b1, bits[i]);
      end
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_overlap_stream();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      send(16'b10101, 5);
   endtask

   task automatic test_nonoverlap_rehit();
      send(16'b101, 3);
   endtask

   task automatic test_clear();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send(16'b10, 2);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      send(16'b01, 2);
   endtask

   task automatic test_gaps();
      logic [2:0] b;
      b = 3'b101;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 2; i >= 0; i--) begin
         step(1'b1, 1'b0, 1'b1, b[i]);
         for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 1'b0, b[i]);
      end
   endtask

   task automatic test_saturation();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send(16'b10101010101, 11);
   endtask

   task automatic test_enable();
      send(16'b10, 2);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      send(16'b101, 3);
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send(16'b10, 2);
      do_reset("reset_mid");
      send(16'b1, 1);
      send(16'b01, 2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send(16'b1011010101, 10);
   endtask

   initial begin
      reset_n = 1'b0;
      en = 1'b0; clear = 1'b0; x_valid = 1'b0; x_in = 1'b0;
      len_o = 0; hist_o = 2'b00; cnt_o = 0;
      len_n = 0; hist_n = 2'b00; cnt_n = 0;
      test_reset();
      test_overlap_stream();
      test_nonoverlap_rehit();
      test_clear();
      test_gaps();
      test_saturation();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
